// File: rtl/matrix_result_tx.sv
// matrix_result_tx
//   UART transmit end of the matrix accelerator. On start, streams the
//   dim_m x dim_p result matrix back to the host as 32-bit words, row-major,
//   MSB byte first, 8N1 framing. Result storage is read through a
//   row/column address port with one cycle of read latency.
//
//   Optional build macro: MATRIX_TX_HEADER_EN
//     defined   -> two header words {dim_m} and {dim_p} precede the data
//     undefined -> data words only, no header logic
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   1-cycle send request, sampled only in IDLE
//   dim_m    in   rows to send, latched on accepted start
//   dim_p    in   columns to send, latched on accepted start
//   rd_row   out  result read row address
//   rd_col   out  result read column address
//   rd_data  in   result word, valid 1 cycle after address
//   uart_tx  out  serial line, idle high, registered
//   busy     out  high from accepted start through final stop bit
//   done     out  1-cycle pulse when the transfer ends
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, waiting for start
// FETCH   | address driven for 2 cycles, word captured on the 2nd
// LOAD    | select next byte of the word (MSB first)
// START   | start bit (low) for one bit period
// DATA    | 8 data bits, LSB first
// STOP    | stop bit (high), then next byte / next word / finish
// FINISH  | done pulse visible, return to IDLE

module matrix_result_tx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int MAX_M      = 4,
  parameter int MAX_P      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(MAX_M+1)-1:0] dim_m,
  input  logic [$clog2(MAX_P+1)-1:0] dim_p,
  output logic [$clog2(MAX_M)-1:0]   rd_row,
  output logic [$clog2(MAX_P)-1:0]   rd_col,
  input  logic [31:0]                rd_data,
  output logic                       uart_tx,
  output logic                       busy,
  output logic                       done
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int MW = $clog2(MAX_M + 1);
  localparam int PW = $clog2(MAX_P + 1);
  localparam int RW = $clog2(MAX_M);
  localparam int CW = $clog2(MAX_P);
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [MW-1:0] MAX_M_V  = MW'(MAX_M);
  localparam logic [PW-1:0] MAX_P_V  = PW'(MAX_P);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_FINISH
  } state_t;

  state_t         state;
  logic [MW-1:0]  dm_q;
  logic [PW-1:0]  dp_q;
  logic [31:0]    word;
  logic [7:0]     tx_byte;
  logic [1:0]     byte_idx;
  logic [2:0]     bit_idx;
  logic [TW-1:0]  bit_cnt;
  logic           fetch_cnt;

  logic           dims_ok;
  logic           bit_end;
  logic           last_row;
  logic           last_col;
  logic           hdr_pending;
  logic [31:0]    fetch_word;

  assign dims_ok  = (dim_m != '0) && (dim_p != '0) &&
                    (dim_m <= MAX_M_V) && (dim_p <= MAX_P_V);
  assign bit_end  = (bit_cnt == BIT_LAST);
  assign last_row = (MW'(rd_row) == dm_q - MW'(1));
  assign last_col = (PW'(rd_col) == dp_q - PW'(1));

`ifdef MATRIX_TX_HEADER_EN
  // hdr_idx counts header words already sent; 2 means header complete.
  logic [1:0] hdr_idx;

  assign hdr_pending = (hdr_idx != 2'd2);
  assign fetch_word  = !hdr_pending     ? rd_data     :
                       (hdr_idx == 2'd0) ? 32'(dm_q) : 32'(dp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx <= 2'd0;
    end else if (state == S_IDLE && start && dims_ok) begin
      hdr_idx <= 2'd0;
    end else if (state == S_STOP && bit_end && byte_idx == 2'd3 && hdr_pending) begin
      hdr_idx <= hdr_idx + 2'd1;
    end
  end
`else
  assign hdr_pending = 1'b0;
  assign fetch_word  = rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dm_q      <= '0;
      dp_q      <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      word      <= '0;
      tx_byte   <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      fetch_cnt <= 1'b0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!dims_ok) begin
              // Rejected request: report completion without touching the line.
              done <= 1'b1;
            end else begin
              dm_q      <= dim_m;
              dp_q      <= dim_p;
              rd_row    <= '0;
              rd_col    <= '0;
              byte_idx  <= '0;
              fetch_cnt <= 1'b0;
              busy      <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          // Address was set on entry; rd_data is valid in the 2nd cycle.
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            fetch_cnt <= 1'b0;
            word      <= fetch_word;
            byte_idx  <= '0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          tx_byte <= word[31 - 8*int'(byte_idx) -: 8];
          bit_cnt <= '0;
          uart_tx <= 1'b0;
          state   <= S_START;
        end

        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= tx_byte[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + TW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= S_LOAD;
            end else if (hdr_pending) begin
              // Header words do not advance the result address.
              fetch_cnt <= 1'b0;
              state     <= S_FETCH;
            end else if (last_row && last_col) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              if (last_col) begin
                rd_col <= '0;
                rd_row <= rd_row + RW'(1);
              end else begin
                rd_col <= rd_col + CW'(1);
              end
              fetch_cnt <= 1'b0;
              state     <= S_FETCH;
            end
          end else begin
            bit_cnt <= bit_cnt + TW'(1);
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
